window3x3_gen: RTL
==================

Name: window3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator; sits directly upstream of the comparer2-based sorting network in the order-statistics (min/median/max) filter.
- Accepts a raster-scan pixel stream, one pixel per valid cycle, and buffers the two previous image lines internally.
- Emits the nine pixels of every fully-populated 3x3 window as one flattened bus, with a valid strobe and an end-of-frame marker.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; legal range is 3 or more.
- IMG_HEIGHT, 480, lines per frame; legal range is 3 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- arstn  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  pixel sample.
- din_valid  input  1  din is accepted on every rising edge where this is high.
- din_sof  input  1  marks the accepted pixel as row 0, col 0 of a new frame; only sampled when din_valid is high.
- win  output  9*DATA_WIDTH  window. Slice k = 3*i+j, bits [DATA_WIDTH*k +: DATA_WIDTH], holds the pixel at (row r-2+i, col c-2+j). (r,c) is the newest accepted pixel. k=0 is the oldest (top-left), k=4 is the centre, k=8 is (r,c).
- win_valid  output  1  win holds a new complete window this cycle.
- win_last  output  1  win holds the final window of the frame; qualified by win_valid.

Behaviour:
- Reset (arstn low, asynchronous):
  - col and row counters = 0.
  - win = 0, win_valid = 0, win_last = 0.
  - Column shift registers = 0.
  - Line-buffer RAMs are not reset.
- Counters:
  - col is $clog2(IMG_WIDTH) bits; row is $clog2(IMG_HEIGHT) bits.
  - On an accepted pixel, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0, so back-to-back frames need no sof.
- din_sof with din_valid:
  - The pixel is treated as (0,0); afterwards col=1, row=0, regardless of the prior counter state.
  - Line-buffer contents from the aborted frame are never exposed, because windows require row of 2 or more.
- Line buffers:
  - Two buffers, each IMG_WIDTH deep, indexed by col.
  - On an accepted pixel: lb1[col] <= lb0[col] and lb0[col] <= din, using the read-before-write value of lb0.
  - Implementation may use inferred RAM with registered read, provided the output timing below holds.
- Column shift:
  - Three 3-deep shift registers (top, middle, bottom).
  - Each accepted pixel shifts in lb1[col], lb0[col] and din respectively.
  - No shift occurs when din_valid is low.
- Output timing, latency 1:
  - On the cycle after accepting pixel (r,c) with r of 2 or more and c of 2 or more: win_valid=1 and win = the window with (r,c) at slice 8.
  - win_last=1 additionally when r=IMG_HEIGHT-1 and c=IMG_WIDTH-1.
  - Otherwise win_valid=0 and win_last=0, and win holds its last value.
- Valid windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - Border pixels produce no window; no padding or replication is performed.
  - No window spans a line boundary. The c of 2 or more rule suppresses the two windows straddling a wrap.
- Flow control:
  - There is no backpressure; the downstream stage must accept every win_valid cycle.
  - Gaps in din_valid are allowed anywhere, including inside a line; output content is independent of gap pattern.
- Reset mid-frame: all state is cleared as above. The next accepted pixel is (0,0) whether or not sof is set.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, din=16*r+c, din_valid constant high:
  - Exactly 6 win_valid pulses.
  - First window, one cycle after 0x22: {00,01,02,10,11,12,20,21,22} (slice 0..8).
  - Last window: {12,13,14,22,23,24,32,33,34} with win_last=1.
- Same frame with din_valid toggling 1/0 every cycle -> identical 6 windows in identical order, each one cycle after its pixel; win unchanged between pulses.
- Two back-to-back frames, no sof, second frame din=0x80+16*r+c:
  - 12 pulses total; win_last on pulses 6 and 12.
  - Pulse 7 is {80,81,82,90,91,92,A0,A1,A2}, with no stale first-frame pixels.
- Abort after 7 pixels by sending din_sof with a new frame:
  - No win_valid until new (2,2).
  - Then 6 windows of the new frame only.
- Assert arstn low mid-frame (after 12 pixels):
  - win, win_valid and win_last read 0 immediately (asynchronous).
  - After release, a full frame yields exactly 6 correct windows.
- IMG_WIDTH=3, IMG_HEIGHT=3, 9 pixels -> exactly 1 window, with win_valid=1 and win_last=1 together.

Source files
------------

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus three 3-deep column
// shift registers produce one complete window per accepted pixel away from the border.
module window3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    din_sof,
  output logic [9*DATA_WIDTH-1:0] win,
  output logic                    win_valid,
  output logic                    win_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;

  // Index 2 is the newest column, index 0 the oldest.
  logic [2:0][DATA_WIDTH-1:0] sr_top, sr_mid, sr_bot;

  logic [9*DATA_WIDTH-1:0] win_next;
  logic                    emit;
  logic                    emit_last;

  // A start-of-frame pixel is placed at (0,0) whatever the counters hold.
  always_comb begin
    cur_col   = din_sof ? '0 : col;
    cur_row   = din_sof ? '0 : row;
    lb0_q     = lb0[cur_col];
    lb1_q     = lb1[cur_col];
    emit      = din_valid && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
    emit_last = emit && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    win_next  = {din,   sr_bot[2], sr_bot[1],
                 lb0_q, sr_mid[2], sr_mid[1],
                 lb1_q, sr_top[2], sr_top[1]};
  end

  // Line buffers carry no reset; rows 0 and 1 of a frame are never exposed.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      lb1[cur_col] <= lb0_q;
      lb0[cur_col] <= din;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      col       <= '0;
      row       <= '0;
      sr_top    <= '0;
      sr_mid    <= '0;
      sr_bot    <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= emit;
      win_last  <= emit_last;
      if (emit)
        win <= win_next;
      if (din_valid) begin
        sr_top <= {lb1_q, sr_top[2:1]};
        sr_mid <= {lb0_q, sr_mid[2:1]};
        sr_bot <= {din,   sr_bot[2:1]};
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

endmodule
